// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths and register-index constants
package rv32i_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: index -> data mux with x0 forced to zero and optional write-through forwarding
module reg_file_rd_port
  import rv32i_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int AW = REG_ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic [AW-1:0]              addr,
  input  logic [2**AW-1:0][DW-1:0]   regs,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              data
);
  assign data = (addr == AW'(ZERO_REG)) ? '0 :
                (BYPASS && wr_en && wr_addr == addr) ? wr_data : regs[addr];
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 RV32I register file, two async read ports, one sync write port, debug read port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the two operand read ports.
module reg_file
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Read_register1,
  input  logic [ADDR_WIDTH-1:0] Read_register2,
  input  logic [ADDR_WIDTH-1:0] Write_register,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] Read_data1,
  output logic [DATA_WIDTH-1:0] Read_data2,
  input  logic [ADDR_WIDTH-1:0] Debug_addr,
  output logic [DATA_WIDTH-1:0] Debug_data
);
  localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DEPTH-1:1][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] view;
  logic we;
  assign we = RegWrite && !rst && Write_register != ADDR_WIDTH'(ZERO_REG);
  // x0 has no storage; the view pads a constant zero entry below x1
  assign view = {regs, {DATA_WIDTH{1'b0}}};
  always_ff @(posedge clk) begin
    if (rst) regs <= {(DEPTH-1){RESET_VALUE}};
    else if (we) regs[Write_register] <= Write_data;
  end
  always_ff @(posedge clk) assert (!$isunknown(RegWrite)) else $error("RegWrite is X/Z");
  reg_file_rd_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .BYPASS(BYP)) u_rd1 (
    .addr(Read_register1), .regs(view), .wr_en(we), .wr_addr(Write_register),
    .wr_data(Write_data), .data(Read_data1));
  reg_file_rd_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .BYPASS(BYP)) u_rd2 (
    .addr(Read_register2), .regs(view), .wr_en(we), .wr_addr(Write_register),
    .wr_data(Write_data), .data(Read_data2));
  reg_file_rd_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .BYPASS(1'b0)) u_dbg (
    .addr(Debug_addr), .regs(view), .wr_en(we), .wr_addr(Write_register),
    .wr_data(Write_data), .data(Debug_data));
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd, dbg;
  logic [31:0] wdata, rdata1, rdata2, dbg_data;
  logic we;
  int compared = 0;
  int mismatched = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file dut (
    .clk(clk), .rst(rst), .Read_register1(rs1), .Read_register2(rs2),
    .Write_register(rd), .Write_data(wdata), .RegWrite(we),
    .Read_data1(rdata1), .Read_data2(rdata2), .Debug_addr(dbg), .Debug_data(dbg_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; rd = '0; wdata = '0; rs1 = '0; rs2 = '0; dbg = '0;
    tick;
    rst = 1'b0;
    dbg = 5'd5; #1;
    chk("init_x5", dbg_data, 32'h0);
    // preload x5, then reset with a competing write to x6
    we = 1'b1; rd = 5'd5; wdata = 32'hDEAD_BEEF;
    tick;
    chk("preload_x5", dbg_data, 32'hDEAD_BEEF);
    rst = 1'b1; rd = 5'd6; wdata = 32'h1234_5678;
    #1;
    chk("prereset_x5", dbg_data, 32'hDEAD_BEEF);
    tick;
    rst = 1'b0; we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      dbg = 5'(i); #1;
      chk($sformatf("reset_x%0d", i), dbg_data, 32'h0);
    end
    // basic write/read
    we = 1'b1; rd = 5'd1; wdata = 32'h0000_0010;
    tick;
    rd = 5'd2; wdata = 32'hFFFF_FFF0;
    tick;
    we = 1'b0; rs1 = 5'd1; rs2 = 5'd2; #1;
    chk("basic_rd1", rdata1, 32'h0000_0010);
    chk("basic_rd2", rdata2, 32'hFFFF_FFF0);
    // x0 protection
    we = 1'b1; rd = 5'd0; wdata = 32'h1234_5678; rs1 = 5'd0; rs2 = 5'd0; dbg = 5'd0; #1;
    chk("x0_pre_rd1", rdata1, 32'h0);
    tick;
    we = 1'b0; #1;
    chk("x0_post_rd1", rdata1, 32'h0);
    chk("x0_post_rd2", rdata2, 32'h0);
    chk("x0_post_dbg", dbg_data, 32'h0);
    // same-cycle read/write on x7
    we = 1'b1; rd = 5'd7; wdata = 32'h1;
    tick;
    wdata = 32'h2; rs1 = 5'd7; rs2 = 5'd7; dbg = 5'd7; #1;
    chk("raw_pre_rd1", rdata1, BYP ? 32'h2 : 32'h1);
    chk("raw_pre_rd2", rdata2, BYP ? 32'h2 : 32'h1);
    chk("raw_pre_dbg", dbg_data, 32'h1);
    tick;
    we = 1'b0; #1;
    chk("raw_post_rd1", rdata1, 32'h2);
    chk("raw_post_rd2", rdata2, 32'h2);
    chk("raw_post_dbg", dbg_data, 32'h2);
    // disabled write leaves x9 alone
    rd = 5'd9; wdata = 32'hAAAA_AAAA; rs1 = 5'd9; dbg = 5'd9; #1;
    chk("nowe_pre_rd1", rdata1, 32'h0);
    tick;
    chk("nowe_post_dbg", dbg_data, 32'h0);
    // sweep: xi = i * 0x0101_0101
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i); wdata = i * 32'h0101_0101;
      tick;
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); dbg = 5'(i); #1;
      chk($sformatf("sweep_rd1_x%0d", i), rdata1, i * 32'h0101_0101);
      chk($sformatf("sweep_rd2_x%0d", 31 - i), rdata2, (31 - i) * 32'h0101_0101);
      chk($sformatf("sweep_dbg_x%0d", i), dbg_data, i * 32'h0101_0101);
    end
    // mid-program reset clears everything
    rst = 1'b1;
    tick;
    rst = 1'b0; rs1 = 5'd31; rs2 = 5'd1; dbg = 5'd16; #1;
    chk("midrst_rd1", rdata1, 32'h0);
    chk("midrst_rd2", rdata2, 32'h0);
    chk("midrst_dbg", dbg_data, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
